// File: rtl/cla_pipe_adder_if.sv
// Operand/result bundle for cla_pipe_adder: valid/ready request side and valid/ready result side.
// Latency: none (wires only).
// Backpressure: out_ready from the consumer; in_ready back to the producer.
// Ports: in_valid/in_ready/a/b/cin/sub (request), out_valid/out_ready/sum/cout/ovf (result).
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // master: operand producer and result consumer
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // slave: the adder itself
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit lookahead group per stage.
// Latency: STAGES = WIDTH/GROUP register stages (counting the accepting edge), one op/cycle.
// Backpressure: whole pipe holds when out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Ports: clk, reset (sync, active-high); bus (slave modport of cla_pipe_adder_if):
//   in_valid/in_ready/a/b/cin/sub in, out_valid/out_ready/sum/cout/ovf out.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic             clk,
  input logic             reset,
  cla_pipe_adder_if.slave bus
);
  localparam int STAGES = WIDTH / GROUP;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  generate
    if (GROUP < 1 || GROUP > WIDTH || (WIDTH % GROUP) != 0) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH (%0d) must be a multiple of GROUP (%0d), 1 <= GROUP <= WIDTH",
             WIDTH, GROUP);
    end
  endgenerate

  // Per-stage registers. r_b holds the already-conditioned operand B' (b or ~b),
  // r_s accumulates resolved sum bits, r_c is the carry out of the last resolved group.
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;

  logic             w_vld_nxt [STAGES];
  logic [WIDTH-1:0] w_a_nxt   [STAGES];
  logic [WIDTH-1:0] w_b_nxt   [STAGES];
  logic [WIDTH-1:0] w_s_nxt   [STAGES];
  logic             w_c_nxt   [STAGES];
  logic             w_ovf_nxt;
  logic             w_adv;

  // One lookahead group: returns {carry_out, sum}. Every carry is built as a flat
  // sum of products g_j & p_{j+1..i} plus p_{0..i} & c0, so nothing ripples inside a group.
  function automatic logic [GROUP:0] f_cla(input logic [GROUP-1:0] ga,
                                           input logic [GROUP-1:0] gb,
                                           input logic             c0);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             t;
    p    = ga ^ gb;
    g    = ga & gb;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      t = c0;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // The whole pipe advances together; a full output register that is not being
  // taken is the only thing that can stall it.
  assign w_adv        = !r_vld[LAST] || bus.out_ready;
  assign bus.in_ready = w_adv;
  assign bus.out_valid = r_vld[LAST];
  assign bus.sum      = r_s[LAST];
  assign bus.cout     = r_c[LAST];
  assign bus.ovf      = r_ovf;

  always_comb begin
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_s;
    logic             w_c;
    logic             w_v;
    logic [GROUP:0]   w_r;
    int               w_p;
    w_a = '0;
    w_b = '0;
    w_s = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    w_r = '0;
    w_p = 0;
    for (int k = 0; k < STAGES; k++) begin
      w_p = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        // Stage 0 conditions the operands: subtract is A + ~B + 1, cin ignored.
        w_v = bus.in_valid;
        w_a = bus.a;
        w_b = bus.sub ? ~bus.b : bus.b;
        w_s = '0;
        w_c = bus.sub ? 1'b1 : bus.cin;
      end else begin
        w_v = r_vld[w_p];
        w_a = r_a[w_p];
        w_b = r_b[w_p];
        w_s = r_s[w_p];
        w_c = r_c[w_p];
      end
      w_r = f_cla(w_a[k*GROUP +: GROUP], w_b[k*GROUP +: GROUP], w_c);
      w_s[k*GROUP +: GROUP] = w_r[GROUP-1:0];
      w_vld_nxt[k] = w_v;
      w_a_nxt[k]   = w_a;
      w_b_nxt[k]   = w_b;
      w_s_nxt[k]   = w_s;
      w_c_nxt[k]   = w_r[GROUP];
    end
    // Signed overflow: like-signed operands (after conditioning) giving an unlike-signed sum.
    w_ovf_nxt = (w_a_nxt[LAST][MSB] == w_b_nxt[LAST][MSB]) &&
                (w_s_nxt[LAST][MSB] != w_a_nxt[LAST][MSB]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_nxt[k];
        r_a[k]   <= w_a_nxt[k];
        r_b[k]   <= w_b_nxt[k];
        r_s[k]   <= w_s_nxt[k];
        r_c[k]   <= w_c_nxt[k];
      end
      r_ovf <= w_ovf_nxt;
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: 16/4 main instance plus 8/2 and 8/8 instances.
// Expected results come from integer arithmetic on the operands (unsigned and signed views).
// Results are popped by monitors whenever out_valid && out_ready, independent of the drivers.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q16[$];
  exp_t q2[$];
  exp_t q8[$];
  exp_t e16, e2, e8;
  bit   mon_en  = 1'b0;
  bit   rnd_rdy = 1'b0;
  bit   stalled = 1'b0;
  logic [15:0] h_sum;
  logic        h_cout, h_ovf;
  int   seen_vld = 0;

  cla_pipe_adder_if #(.WIDTH(16)) m16 ();
  cla_pipe_adder_if #(.WIDTH(8))  s2 ();
  cla_pipe_adder_if #(.WIDTH(8))  s8 ();

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u16 (.clk(clk), .reset(reset), .bus(m16));
  cla_pipe_adder #(.WIDTH(8),  .GROUP(2)) u2  (.clk(clk), .reset(reset), .bus(s2));
  cla_pipe_adder #(.WIDTH(8),  .GROUP(8)) u8  (.clk(clk), .reset(reset), .bus(s8));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: exact integer add/subtract; cout = result reached 2^w (sub: no borrow);
  // ovf = signed result outside the w-bit two's-complement range.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    int mod, ua, ub, sa, sb, full, sres;
    mod  = 1 << w;
    ua   = int'(a) % mod;
    ub   = int'(b) % mod;
    full = sub ? ua - ub + mod : ua + ub + int'(cin);
    sa   = (ua >= mod / 2) ? ua - mod : ua;
    sb   = (ub >= mod / 2) ? ub - mod : ub;
    sres = sub ? sa - sb : sa + sb + int'(cin);
    e.sum  = 16'(full % mod);
    e.cout = (full >= mod);
    e.ovf  = (sres >= mod / 2) || (sres < -(mod / 2));
    e.acc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  // Consumer side of the main instance: random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    m16.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Main monitor
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready_rule", m16.in_ready, !m16.out_valid || m16.out_ready);
      if (stalled) begin
        check("stall_valid", m16.out_valid, 1);
        check("stall_sum", m16.sum, h_sum);
        check("stall_cout", m16.cout, h_cout);
        check("stall_ovf", m16.ovf, h_ovf);
      end
      if (m16.out_valid) seen_vld++;
      if (m16.out_valid && m16.out_ready) begin
        if (q16.size() == 0) flag("g4_unexpected_result");
        else begin
          e16 = q16.pop_front();
          check("g4_sum", m16.sum, e16.sum);
          check("g4_cout", m16.cout, e16.cout);
          check("g4_ovf", m16.ovf, e16.ovf);
          if (e16.lat) check("g4_latency", cyc - e16.acc + 1, 4);
        end
      end
      stalled = m16.out_valid && !m16.out_ready;
      h_sum   = m16.sum;
      h_cout  = m16.cout;
      h_ovf   = m16.ovf;
    end
  end

  // Narrow-instance monitors (out_ready held at 1, so every result has fixed latency)
  always @(negedge clk) begin
    if (mon_en && s2.out_valid) begin
      if (q2.size() == 0) flag("g2_unexpected_result");
      else begin
        e2 = q2.pop_front();
        check("g2_sum", s2.sum, e2.sum[7:0]);
        check("g2_cout", s2.cout, e2.cout);
        check("g2_ovf", s2.ovf, e2.ovf);
        check("g2_latency", cyc - e2.acc + 1, 4);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && s8.out_valid) begin
      if (q8.size() == 0) flag("g8_unexpected_result");
      else begin
        e8 = q8.pop_front();
        check("g8_sum", s8.sum, e8.sum[7:0]);
        check("g8_cout", s8.cout, e8.cout);
        check("g8_ovf", s8.ovf, e8.ovf);
        check("g8_latency", cyc - e8.acc + 1, 1);
      end
    end
  end

  // Offer one operand set to the main instance; expected result queued at the accepting edge.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input bit lat);
    exp_t e;
    bit   ok;
    e = model(16, a, b, cin, sub);
    e.lat = lat;
    m16.a = a;
    m16.b = b;
    m16.cin = cin;
    m16.sub = sub;
    m16.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (m16.in_ready) begin
        e.acc = cyc + 1;
        q16.push_back(e);
        ok = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m16.in_valid = 1'b0;
    if (!ok) flag("send16_timeout");
  endtask

  task automatic drain16();
    for (int t = 0; t < 1000 && q16.size() != 0; t++) @(negedge clk);
    if (q16.size() != 0) begin
      flag("drain16_timeout");
      q16.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_small(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic sub);
    exp_t e;
    s2.a = a;  s2.b = b;  s2.cin = cin;  s2.sub = sub;  s2.in_valid = 1'b1;
    s8.a = a;  s8.b = b;  s8.cin = cin;  s8.sub = sub;  s8.in_valid = 1'b1;
    @(negedge clk);
    if (!(s2.in_ready && s8.in_ready)) flag("small_in_ready");
    e = model(8, {8'h00, a}, {8'h00, b}, cin, sub);
    e.acc = cyc + 1;
    q2.push_back(e);
    q8.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] cv [5];

  initial begin
    reset = 1'b1;
    m16.in_valid = 1'b0; m16.a = '0; m16.b = '0; m16.cin = 1'b0; m16.sub = 1'b0;
    s2.in_valid = 1'b0;  s2.a = '0;  s2.b = '0;  s2.cin = 1'b0;  s2.sub = 1'b0;  s2.out_ready = 1'b1;
    s8.in_valid = 1'b0;  s8.a = '0;  s8.b = '0;  s8.cin = 1'b0;  s8.sub = 1'b0;  s8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", m16.out_valid, 0);
    check("rst_sum", m16.sum, 0);
    check("rst_cout", m16.cout, 0);
    check("rst_ovf", m16.ovf, 0);
    check("rst_in_ready", m16.in_ready, 1);
    check("rst_g2_valid", s2.out_valid, 0);
    check("rst_g8_valid", s8.out_valid, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed adds/subtracts, no backpressure, latency checked
    send16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    drain16();
    send16(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1);
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    send16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    send16(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    send16(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
    send16(16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1);
    send16(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1);
    send16(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    drain16();

    // Random stream with random gaps and random out_ready
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    drain16();
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three operations in flight: none may emerge
    send16(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    send16(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0);
    send16(16'h5555, 16'h6666, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    q16.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_out_valid", m16.out_valid, 0);
    check("midrst_sum", m16.sum, 0);
    check("midrst_cout", m16.cout, 0);
    check("midrst_ovf", m16.ovf, 0);
    seen_vld = 0;
    @(negedge clk);
    check("midrst_in_ready", m16.in_ready, 1);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;
    check("midrst_no_ghost", seen_vld, 0);
    send16(16'hABCD, 16'h0F0F, 1'b1, 1'b0, 1'b1);
    drain16();

    // Narrow instances: corner grid then random stream
    cv[0] = 8'h00; cv[1] = 8'h01; cv[2] = 8'h7F; cv[3] = 8'h80; cv[4] = 8'hFF;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int k = 0; k < 4; k++)
          send_small(cv[i], cv[j], k[0], k[1]);
    for (int i = 0; i < 2000; i++)
      send_small(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    s2.in_valid = 1'b0;
    s8.in_valid = 1'b0;
    for (int t = 0; t < 50 && (q2.size() != 0 || q8.size() != 0); t++) @(negedge clk);
    if (q2.size() != 0) flag("g2_results_missing");
    if (q8.size() != 0) flag("g8_results_missing");
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
